// File: rtl/countdown_sequencer.sv
// countdown_sequencer: loadable 4-bit down counter with a power-of-two tick
// prescaler, one-shot or auto-reload operation, an abort input and a
// registered single-cycle expiry pulse.
module countdown_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] load_val,
   input  logic [1:0] prescale,
   input  logic       mode,
   output logic [3:0] q,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      EXPIRE = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] shadow_val;
   logic [1:0] shadow_pre;
   logic       shadow_mode;
   logic [2:0] pre_cnt;
   logic [2:0] tick_limit;
   logic       tick;

   // Terminal prescaler value (2^prescale - 1) taken from the captured setting
   always_comb begin
      tick_limit = 3'd0;
      case (shadow_pre)
         2'd0:    tick_limit = 3'd0;
         2'd1:    tick_limit = 3'd1;
         2'd2:    tick_limit = 3'd3;
         default: tick_limit = 3'd7;
      endcase
   end

   assign tick = (pre_cnt == tick_limit);
   assign busy = (state != IDLE);

   // Sequencer: start/stop handling, prescaled countdown, expiry and reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         q           <= 4'd0;
         done        <= 1'b0;
         pre_cnt     <= 3'd0;
         shadow_val  <= 4'd0;
         shadow_pre  <= 2'd0;
         shadow_mode <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  shadow_val  <= load_val;
                  shadow_pre  <= prescale;
                  shadow_mode <= mode;
                  q           <= load_val;
                  pre_cnt     <= 3'd0;
                  if (load_val != 4'd0) begin
                     state <= RUN;
                  end else begin
                     state <= EXPIRE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (tick) begin
                  pre_cnt <= 3'd0;
                  if (q != 4'd0) begin
                     q <= q - 4'd1;
                  end
                  if (q <= 4'd1) begin
                     state <= EXPIRE;
                     done  <= 1'b1;
                  end
               end else begin
                  pre_cnt <= pre_cnt + 3'd1;
               end
            end
            EXPIRE: begin
               if (stop) begin
                  state <= IDLE;
               end else if (shadow_mode && (shadow_val != 4'd0)) begin
                  q       <= shadow_val;
                  pre_cnt <= 3'd0;
                  state   <= RUN;
               end else begin
                  q     <= 4'd0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/countdown_sequencer.md
COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request to load and run a countdown; sampled on rising CLK.
REQ-005 STOP  input  1  abort request; sampled on rising CLK.
REQ-006 LOAD_VAL  input  4  countdown start value.
REQ-007 PRESCALE  input  2  tick divider exponent: count decrements once every 2^PRESCALE cycles (1, 2, 4 or 8).
REQ-008 MODE  input  1  0 = one-shot, 1 = auto-reload.
REQ-009 Q  output  4  current count value, registered.
REQ-010 BUSY  output  1  high when the state is not IDLE.
REQ-011 DONE  output  1  single-cycle expiry pulse, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and EXPIRE.
REQ-013 On an edge in IDLE with START=1 and STOP=0, the block SHALL capture LOAD_VAL, PRESCALE and MODE into shadow registers, set Q=LOAD_VAL and clear the prescale counter.
REQ-014 On that same edge, the next state SHALL be RUN when LOAD_VAL != 0, and EXPIRE when LOAD_VAL == 0.
REQ-015 While in RUN, the block SHALL use only the shadow values; changes on LOAD_VAL, PRESCALE and MODE SHALL have no effect.
REQ-016 The prescale counter SHALL be 3 bits wide and increment every cycle in RUN.
REQ-017 A tick SHALL occur when the prescale counter equals 2^PRESCALE-1; the prescale counter SHALL wrap to 0 on a tick.
REQ-018 On a tick in RUN, Q SHALL decrement by 1.
REQ-019 If a tick occurs with Q==1, Q SHALL become 0 and the next state SHALL be EXPIRE.
REQ-020 Q SHALL never wrap from 0 to 15.
REQ-021 DONE SHALL be 1 exactly while in EXPIRE, which lasts one cycle.
REQ-022 From EXPIRE with shadow MODE=1 and shadow value != 0, the block SHALL reload Q from the shadow value, clear the prescaler and go to RUN.
REQ-023 From EXPIRE in all other cases (including shadow value 0), the next state SHALL be IDLE and Q SHALL hold 0.
REQ-024 STOP=1 in RUN or EXPIRE SHALL force IDLE on the next edge, freeze Q at its current value, and suppress any pending DONE.
REQ-025 STOP SHALL have priority over START; START and STOP together in IDLE SHALL leave the block in IDLE unchanged.
REQ-026 START in RUN or EXPIRE SHALL be ignored; a restart requires STOP first.
REQ-027 In IDLE without START, Q SHALL hold its value.
REQ-028 BUSY SHALL be decoded from the registered state, and SHALL be 1 in RUN and EXPIRE.

Reset
REQ-029 While RESET=1, independent of CLK: state=IDLE, Q=0, DONE=0, BUSY=0, prescale counter=0, shadow registers=0.
REQ-030 Reset asserted mid-countdown SHALL abort the countdown immediately, with no DONE pulse.
REQ-031 After RESET deasserts, the block SHALL act on the first rising CLK edge.

Verification
REQ-032 LOAD_VAL=3, PRESCALE=0, MODE=0, START pulse at edge n -> Q=3,2,1,0 at edges n..n+3; DONE=1 only after edge n+3; BUSY=0 and Q=0 after edge n+4.
REQ-033 LOAD_VAL=2, PRESCALE=2 -> Q holds each value for 4 cycles; DONE rises 8 cycles after the start edge.
REQ-034 LOAD_VAL=2, MODE=1, PRESCALE=0 -> Q sequence 2,1,0,2,1,0...; DONE pulses every 3 cycles until STOP; after STOP, Q frozen and BUSY=0.
REQ-035 LOAD_VAL=0 with START -> EXPIRE on the next edge, one DONE pulse, then IDLE, even when MODE=1.
REQ-036 STOP asserted with Q=1, one cycle before the expiring tick -> IDLE, Q=1, no DONE; START and STOP together in IDLE -> no change.
REQ-037 RESET pulsed asynchronously (between edges) during RUN with Q=5 -> Q=0, BUSY=0 immediately; LOAD_VAL changed mid-run -> no effect on the running count.
